mole_scorer: RTL and testbench

Downstream consumer of the mole LED pattern driven onto LEDR by the random mole generator. Synchronises the 18 slide switches, treats any switch toggle as a whack, and judges each mole as hit, wrong-whack or timeout. Keeps a saturating score and a miss count, and declares game over at a miss limit. Score feeds the display path; `mole_clear` asks the upstream generator to extinguish the current mole.

---
 rtl/game_pkg.sv | 21 ++
 rtl/sw_sync_edge.sv | 31 +++
 rtl/mole_scorer.sv | 149 ++++++++++++++
 tb/tb_mole_scorer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants and the scorer state type for the whack-a-mole game blocks.
package game_pkg;

    // Width of the mole LED pattern and of the slide-switch bank.
    localparam int GAME_N_LEDS         = 18;
    // Default mole lifetime: one second at CLOCK_50.
    localparam int GAME_TIMEOUT_CYCLES = 50_000_000;
    // Largest score that still fits four decimal HEX digits.
    localparam int GAME_MAX_SCORE      = 9999;

    // Scorer FSM states.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ARMED      = 3'd1,
        ST_ACTIVE     = 3'd2,
        ST_RESOLVE    = 3'd3,
        ST_WAIT_CLEAR = 3'd4,
        ST_OVER       = 3'd5
    } scorer_state_t;

endpackage

// File: rtl/sw_sync_edge.sv
// Two-flop synchroniser for raw switches plus a toggle detector against the
// previous synchronised value. Any edge, rising or falling, shows up in o_toggled.
module sw_sync_edge #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_sw,
    output logic [W-1:0] o_toggled
);

    logic [W-1:0] r_sync1;
    logic [W-1:0] r_sync2;
    logic [W-1:0] r_prev;

    // Synchronise the switches and keep last cycle's value; prev always follows.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_toggled = r_sync2 ^ r_prev;

endmodule

// File: rtl/mole_scorer.sv
// Judges each mole shown on LEDR as hit, wrong whack or timeout, keeps a
// saturating score and a miss count, and stops the game at the miss limit.
module mole_scorer
    import game_pkg::*;
#(
    parameter int N_LEDS         = GAME_N_LEDS,
    parameter int TIMEOUT_CYCLES = GAME_TIMEOUT_CYCLES,
    parameter int MAX_SCORE      = GAME_MAX_SCORE,
    parameter int MISS_LIMIT     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [N_LEDS-1:0] mole,
    input  logic [N_LEDS-1:0] sw,
    output logic              mole_clear,
    output logic              hit_pulse,
    output logic              miss_pulse,
    output logic [13:0]       score,
    output logic [1:0]        misses,
    output logic              game_over
);

    // Timer only has to reach TIMEOUT_CYCLES-1; it is cleared before it could wrap.
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [N_LEDS-1:0] w_toggled;
    logic              w_hit;
    logic              w_whack;
    logic              w_timeout;
    logic [1:0]        w_misses_inc;

    scorer_state_t     r_state;
    logic [N_LEDS-1:0] r_target;
    logic [TW-1:0]     r_timer;
    logic              r_is_hit;
    logic [13:0]       r_score;
    logic [1:0]        r_misses;
    logic              r_mole_clear;
    logic              r_hit_pulse;
    logic              r_miss_pulse;
    logic              r_game_over;

    sw_sync_edge #(
        .W (N_LEDS)
    ) u_sw_sync_edge (
        .clk       (clk),
        .reset     (reset),
        .i_sw      (sw),
        .o_toggled (w_toggled)
    );

    assign w_hit        = (w_toggled & r_target) != '0;
    assign w_whack      = w_toggled != '0;
    assign w_timeout    = r_timer == TW'(TIMEOUT_CYCLES - 1);
    assign w_misses_inc = r_misses + 2'd1;

    // Game FSM with mole target latch and lifetime timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_target <= '0;
            r_timer  <= '0;
            r_is_hit <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_timer <= '0;
                    if (enable) r_state <= ST_ARMED;
                end
                ST_ARMED: begin
                    r_timer <= '0;
                    if (!enable) begin
                        r_state <= ST_IDLE;
                    end else if (mole != '0) begin
                        r_target <= mole;
                        r_state  <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (!enable) begin
                        // Pending mole is abandoned without any judgement.
                        r_timer <= '0;
                        r_state <= ST_IDLE;
                    end else if (w_hit || w_whack || w_timeout) begin
                        // Hit has priority over wrong whack and over timeout.
                        r_is_hit <= w_hit;
                        r_timer  <= '0;
                        r_state  <= ST_RESOLVE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_RESOLVE: begin
                    if (!r_is_hit && (w_misses_inc == 2'(MISS_LIMIT)))
                        r_state <= ST_OVER;
                    else
                        r_state <= ST_WAIT_CLEAR;
                end
                ST_WAIT_CLEAR: begin
                    // Wait for the mole to go dark so a repeated pattern is a new mole.
                    if (!enable)        r_state <= ST_IDLE;
                    else if (mole == '0) r_state <= ST_ARMED;
                end
                ST_OVER: begin
                    r_state <= ST_OVER;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered pulses, score and miss counters updated in the resolve cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_score      <= '0;
            r_misses     <= '0;
            r_mole_clear <= 1'b0;
            r_hit_pulse  <= 1'b0;
            r_miss_pulse <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_mole_clear <= 1'b0;
            r_hit_pulse  <= 1'b0;
            r_miss_pulse <= 1'b0;
            r_game_over  <= (r_state == ST_OVER);
            if (r_state == ST_RESOLVE) begin
                r_mole_clear <= 1'b1;
                if (r_is_hit) begin
                    r_hit_pulse <= 1'b1;
                    if (r_score != 14'(MAX_SCORE)) r_score <= r_score + 14'd1;
                end else begin
                    r_miss_pulse <= 1'b1;
                    r_misses     <= w_misses_inc;
                end
            end
        end
    end

    assign mole_clear = r_mole_clear;
    assign hit_pulse  = r_hit_pulse;
    assign miss_pulse = r_miss_pulse;
    assign score      = r_score;
    assign misses     = r_misses;
    assign game_over  = r_game_over;

endmodule

// File: tb/tb_mole_scorer.sv
// Transaction-level bench for mole_scorer: each mole is one transaction whose
// outcome, pulse time and counter values are predicted from the game rules.
module tb_mole_scorer;

    localparam int T   = 100;
    localparam int LIM = 3;
    // Small saturation value keeps the preload phase short.
    localparam int SAT = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [17:0] mole;
    logic [17:0] sw;
    logic        mole_clear;
    logic        hit_pulse;
    logic        miss_pulse;
    logic [13:0] score;
    logic [1:0]  misses;
    logic        game_over;

    int n_vec = 0;
    int n_err = 0;
    int score_m = 0;
    int misses_m = 0;

    mole_scorer #(
        .N_LEDS         (18),
        .TIMEOUT_CYCLES (T),
        .MAX_SCORE      (SAT),
        .MISS_LIMIT     (LIM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mole       (mole),
        .sw         (sw),
        .mole_clear (mole_clear),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .score      (score),
        .misses     (misses),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_clear"}, 32'(mole_clear), 0);
        chk({tag, "_hit"},   32'(hit_pulse), 0);
        chk({tag, "_miss"},  32'(miss_pulse), 0);
        chk({tag, "_score"}, 32'(score), 0);
        chk({tag, "_misses"}, 32'(misses), 0);
        chk({tag, "_over"},  32'(game_over), 0);
    endtask

    // kind: 0 = hit (target plus optional extra), 1 = wrong whack, 2 = timeout.
    // d: ticks after the mole appears before the switches are flipped.
    task automatic run_round(input int kind, input int bitn, input int d, input logic [17:0] extra);
        logic [17:0] tgt;
        logic [17:0] mask;
        int exp_t;
        int t;
        int seen_t;
        int n_extra;
        logic hp, mp, mc, go;
        tgt = 18'd1 << bitn;
        mask = '0;
        hp = 1'b0; mp = 1'b0; mc = 1'b0; go = 1'b0;
        if (kind == 0) begin
            mask = tgt | extra;
        end else if (kind == 1) begin
            mask = extra & ~tgt;
            if (mask == '0) mask = (bitn == 17) ? 18'h00001 : (tgt << 1);
        end
        // Switch sampled d edges after the mole is armed; pulse 3 edges later.
        exp_t = (kind == 2) ? T + 2 : d + 4;
        if (kind == 0) score_m = (score_m < SAT) ? score_m + 1 : SAT;
        else           misses_m = misses_m + 1;

        mole = tgt;
        t = 0;
        seen_t = -1;
        while (t < T + 10 && seen_t < 0) begin
            if (kind != 2 && t == d) sw = sw ^ mask;
            tick;
            t++;
            if (hit_pulse || miss_pulse) begin
                seen_t = t;
                hp = hit_pulse; mp = miss_pulse; mc = mole_clear; go = game_over;
            end
        end
        chk("pulse_tick", 32'(seen_t), 32'(exp_t));
        chk("hit_pulse",  32'(hp), 32'(kind == 0));
        chk("miss_pulse", 32'(mp), 32'(kind != 0));
        chk("mole_clear", 32'(mc), 1);
        chk("score",      32'(score), 32'(score_m));
        chk("misses",     32'(misses), 32'(misses_m));
        chk("over_at_pulse", 32'(go), 0);

        // Mole held lit afterwards must not be judged again.
        n_extra = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (hit_pulse || miss_pulse || mole_clear) n_extra++;
            if (i == 0) chk("game_over", 32'(game_over), 32'(misses_m == LIM));
        end
        chk("stale_pulses", 32'(n_extra), 0);
        mole = '0;
        tick;
        $display("round kind=%0d bit=%0d d=%0d tick=%0d score=%0d misses=%0d",
                 kind, bitn, d, seen_t, score, misses);
    endtask

    initial begin
        int n_p;
        reset = 1'b1; enable = 1'b0; mole = '0; sw = '0;
        tick; tick;
        chk_all_zero("reset");
        reset = 1'b0; enable = 1'b1;
        tick; tick;

        // Directed: hit, wrong whack, simultaneous, hit on the timeout cycle, timeout.
        run_round(0, 2, 10, 18'h0);
        run_round(1, 2, 10, 18'h00020);
        run_round(0, 0, 5, 18'h00200);
        run_round(0, 7, T - 2, 18'h0);
        run_round(2, 17, 0, 18'h0);
        // Random hits drive the score into saturation.
        for (int r = 0; r < 14; r++) begin
            run_round(0, $urandom_range(17, 0), $urandom_range(T - 2, 1),
                      18'($urandom()) & 18'($urandom()));
        end

        // Enable dropped in ACTIVE: mole discarded, no pulse, counters held.
        mole = 18'h00100;
        tick; tick; tick;
        enable = 1'b0;
        tick;
        sw = sw ^ 18'h00100;
        n_p = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (hit_pulse || miss_pulse || mole_clear) n_p++;
        end
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (hit_pulse || miss_pulse || mole_clear) n_p++;
        end
        chk("enable_low_pulses", 32'(n_p), 0);
        chk("enable_low_score", 32'(score), 32'(score_m));
        chk("enable_low_misses", 32'(misses), 32'(misses_m));
        $display("enable-drop score=%0d misses=%0d", score, misses);

        // Reset mid-game clears everything on the next edge.
        reset = 1'b1; sw = '0; mole = '0;
        tick;
        chk_all_zero("midreset");
        tick;
        reset = 1'b0;
        score_m = 0; misses_m = 0;
        tick; tick; tick;

        // Three consecutive timeouts end the game.
        for (int r = 0; r < LIM; r++) run_round(2, $urandom_range(17, 0), 0, 18'h0);

        // Game over: further moles and whacks are ignored.
        mole = 18'h00008;
        n_p = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) sw = sw ^ 18'h00008;
            tick;
            if (hit_pulse || miss_pulse || mole_clear) n_p++;
        end
        chk("over_pulses", 32'(n_p), 0);
        chk("over_flag", 32'(game_over), 1);
        chk("over_misses", 32'(misses), 32'(LIM));
        chk("over_score", 32'(score), 0);
        $display("game-over hold misses=%0d game_over=%0d", misses, game_over);

        reset = 1'b1;
        tick;
        chk_all_zero("final_reset");
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
